// File: rtl/mem_stage.sv
// Memory Access stage: issues loads/stores to a single-ported data memory over a
// req/ready handshake, stalls upstream while busy, traps misaligned/timed-out accesses.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] pc_in_exmem,
  input  logic [31:0] alu_result_in_exmem,
  input  logic [31:0] store_data_in_exmem,
  input  logic [3:0]  Rd_in_exmem,
  input  logic [4:0]  opcode_in_exmem,
  input  logic        reg_write_en_in_exmem,
  input  logic        mem_to_reg_in_exmem,
  input  logic        mem_read_in_exmem,
  input  logic        mem_write_in_exmem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] pc_out_memwb,
  output logic [31:0] alu_result_out_memwb,
  output logic [31:0] mem_read_data_out_memwb,
  output logic [3:0]  Rd_out_memwb,
  output logic [4:0]  opcode_out_memwb,
  output logic        reg_write_en_out_memwb,
  output logic        mem_to_reg_out_memwb,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int CNT_W = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [3:0]  rd;
    logic [4:0]  op;
    logic        rwe;
    logic        m2r;
  } memwb_t;

  function automatic memwb_t pack_memwb(input logic [31:0] pc, input logic [31:0] alu,
                                        input logic [31:0] mrd, input logic [3:0] rd,
                                        input logic [4:0] op, input logic rwe,
                                        input logic m2r);
    memwb_t w;
    w.pc  = pc;
    w.alu = alu;
    w.mrd = mrd;
    w.rd  = rd;
    w.op  = op;
    w.rwe = rwe;
    w.m2r = m2r;
    return w;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  memwb_t           memwb_p2;

  // Instruction held while the access is outstanding
  logic [31:0] pc_p1;
  logic [3:0]  rd_p1;
  logic [4:0]  op_p1;
  logic        rwe_p1;
  logic        m2r_p1;
  logic        load_p1;

  logic mem_op, misaligned, launch, access_wait;

  assign mem_op      = mem_read_in_exmem | mem_write_in_exmem;
  assign misaligned  = mem_op & (alu_result_in_exmem[1:0] != 2'b00);
  assign launch      = (state == IDLE) & enable & mem_op & ~misaligned;
  assign access_wait = (state == ACCESS) & ~dmem_ready & (cnt != CNT_LAST);
  assign stall_out   = launch | access_wait;

  assign pc_out_memwb            = memwb_p2.pc;
  assign alu_result_out_memwb    = memwb_p2.alu;
  assign mem_read_data_out_memwb = memwb_p2.mrd;
  assign Rd_out_memwb            = memwb_p2.rd;
  assign opcode_out_memwb        = memwb_p2.op;
  assign reg_write_en_out_memwb  = memwb_p2.rwe;
  assign mem_to_reg_out_memwb    = memwb_p2.m2r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      memwb_p2   <= '0;
      pc_p1      <= '0;
      rd_p1      <= '0;
      op_p1      <= '0;
      rwe_p1     <= 1'b0;
      m2r_p1     <= 1'b0;
      load_p1    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      fault      <= 1'b0;
      fault_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (!mem_op || misaligned) begin
              memwb_p2 <= pack_memwb(pc_in_exmem, alu_result_in_exmem, 32'h0, Rd_in_exmem,
                                     opcode_in_exmem, reg_write_en_in_exmem & ~misaligned,
                                     mem_to_reg_in_exmem);
              if (misaligned) begin
                fault <= 1'b1;
                if (!fault) fault_pc <= pc_in_exmem;
              end
            end else begin
              // Both read and write set is treated as a load
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write_in_exmem & ~mem_read_in_exmem;
              dmem_addr  <= alu_result_in_exmem;
              dmem_wdata <= store_data_in_exmem;
              cnt        <= '0;
              pc_p1      <= pc_in_exmem;
              rd_p1      <= Rd_in_exmem;
              op_p1      <= opcode_in_exmem;
              rwe_p1     <= reg_write_en_in_exmem;
              m2r_p1     <= mem_to_reg_in_exmem;
              load_p1    <= mem_read_in_exmem;
              memwb_p2   <= '0;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            memwb_p2 <= pack_memwb(pc_p1, dmem_addr, load_p1 ? dmem_rdata : 32'h0, rd_p1,
                                   op_p1, rwe_p1, m2r_p1);
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_LAST) begin
            memwb_p2 <= pack_memwb(pc_p1, dmem_addr, 32'h0, rd_p1, op_p1, 1'b0, m2r_p1);
            fault    <= 1'b1;
            if (!fault) fault_pc <= pc_p1;
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt      <= cnt + 1'b1;
            memwb_p2 <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts stall count,
// request cycles, MEM/WB contents and fault state for each instruction.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] pc_in_exmem, alu_result_in_exmem, store_data_in_exmem;
  logic [3:0]  Rd_in_exmem;
  logic [4:0]  opcode_in_exmem;
  logic        reg_write_en_in_exmem, mem_to_reg_in_exmem, mem_read_in_exmem, mem_write_in_exmem;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_out;
  logic [31:0] pc_out_memwb, alu_result_out_memwb, mem_read_data_out_memwb;
  logic [3:0]  Rd_out_memwb;
  logic [4:0]  opcode_out_memwb;
  logic        reg_write_en_out_memwb, mem_to_reg_out_memwb;
  logic        fault;
  logic [31:0] fault_pc;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pc_in_exmem(pc_in_exmem), .alu_result_in_exmem(alu_result_in_exmem),
    .store_data_in_exmem(store_data_in_exmem), .Rd_in_exmem(Rd_in_exmem),
    .opcode_in_exmem(opcode_in_exmem), .reg_write_en_in_exmem(reg_write_en_in_exmem),
    .mem_to_reg_in_exmem(mem_to_reg_in_exmem), .mem_read_in_exmem(mem_read_in_exmem),
    .mem_write_in_exmem(mem_write_in_exmem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .pc_out_memwb(pc_out_memwb), .alu_result_out_memwb(alu_result_out_memwb),
    .mem_read_data_out_memwb(mem_read_data_out_memwb), .Rd_out_memwb(Rd_out_memwb),
    .opcode_out_memwb(opcode_out_memwb), .reg_write_en_out_memwb(reg_write_en_out_memwb),
    .mem_to_reg_out_memwb(mem_to_reg_out_memwb), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: last MEM/WB contents and sticky fault
  logic [31:0] e_pc, e_alu, e_mrd, m_fault_pc;
  logic [3:0]  e_rd;
  logic [4:0]  e_op;
  logic        e_rwe, e_m2r, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_pc = 0; e_alu = 0; e_mrd = 0; e_rd = 0; e_op = 0; e_rwe = 0; e_m2r = 0;
    m_fault = 0; m_fault_pc = 0;
  endtask

  task automatic chk_memwb(input string tag);
    chk({tag, "_pc"},  pc_out_memwb, e_pc);
    chk({tag, "_alu"}, alu_result_out_memwb, e_alu);
    chk({tag, "_mrd"}, mem_read_data_out_memwb, e_mrd);
    chk({tag, "_rd"},  {28'h0, Rd_out_memwb}, {28'h0, e_rd});
    chk({tag, "_op"},  {27'h0, opcode_out_memwb}, {27'h0, e_op});
    chk({tag, "_rwe"}, {31'h0, reg_write_en_out_memwb}, {31'h0, e_rwe});
    chk({tag, "_m2r"}, {31'h0, mem_to_reg_out_memwb}, {31'h0, e_m2r});
  endtask

  task automatic chk_all_zero(input string tag);
    model_reset();
    chk_memwb(tag);
    chk({tag, "_req"},   {31'h0, dmem_req}, 32'h0);
    chk({tag, "_we"},    {31'h0, dmem_we}, 32'h0);
    chk({tag, "_addr"},  dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
    chk({tag, "_fpc"},   fault_pc, 32'h0);
  endtask

  // Present one instruction (entered just after a rising edge) and run it to completion.
  // lat = ACCESS cycle in which memory answers; 0 or >TIMEOUT means never.
  task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [3:0] rd, input logic [4:0] op,
                           input logic rwe, input logic m2r, input logic mr, input logic mw,
                           input int lat, input logic [31:0] rdata);
    int stalls = 0, acc = 0, cyc = 0;
    bit done = 0, was_req, was_stall, is_mem, is_mis, completes;
    int exp_stalls, exp_acc;
    pc_in_exmem = pc; alu_result_in_exmem = alu; store_data_in_exmem = sd;
    Rd_in_exmem = rd; opcode_in_exmem = op; reg_write_en_in_exmem = rwe;
    mem_to_reg_in_exmem = m2r; mem_read_in_exmem = mr; mem_write_in_exmem = mw;
    is_mem = mr | mw;
    is_mis = is_mem && (alu % 4 != 0);
    completes = is_mem && !is_mis && lat >= 1 && lat <= TIMEOUT;
    while (!done && cyc < 100) begin
      was_req = dmem_req;
      if (was_req) begin
        acc++;
        chk({tag, "_addr"}, dmem_addr, alu);
        chk({tag, "_we"}, {31'h0, dmem_we}, {31'h0, mw & ~mr});
        if (mw && !mr) chk({tag, "_wdata"}, dmem_wdata, sd);
        chk({tag, "_bubble"}, {31'h0, reg_write_en_out_memwb}, 32'h0);
        enable     = 1'($urandom_range(0, 1));
        dmem_ready = (lat > 0 && acc == lat);
        dmem_rdata = dmem_ready ? rdata : $urandom;
      end else begin
        enable     = 1'b1;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      was_stall = stall_out;
      if (was_stall) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (!was_stall) done = 1;
    end
    if (!done) chk({tag, "_finished"}, 32'h0, 32'h1);
    dmem_ready = 1'b0;
    if (!is_mem || is_mis) begin exp_stalls = 0; exp_acc = 0; end
    else if (completes)    begin exp_stalls = lat; exp_acc = lat; end
    else                   begin exp_stalls = TIMEOUT; exp_acc = TIMEOUT; end
    chk({tag, "_stalls"}, stalls, exp_stalls);
    chk({tag, "_reqcyc"}, acc, exp_acc);
    chk({tag, "_req_low"}, {31'h0, dmem_req}, 32'h0);
    e_pc = pc; e_alu = alu; e_rd = rd; e_op = op; e_m2r = m2r;
    e_rwe = rwe && (!is_mem || completes);
    e_mrd = (completes && mr) ? rdata : 32'h0;
    if (is_mis || (is_mem && !completes)) begin
      if (!m_fault) m_fault_pc = pc;
      m_fault = 1;
    end
    chk_memwb(tag);
    chk({tag, "_fault"}, {31'h0, fault}, {31'h0, m_fault});
    chk({tag, "_fpc"}, fault_pc, m_fault_pc);
  endtask

  // enable low: nothing may move, whatever the inputs and dmem_ready look like
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b0;
      pc_in_exmem = $urandom; alu_result_in_exmem = $urandom;
      mem_read_in_exmem = 1'($urandom_range(0, 1)); mem_write_in_exmem = 1'($urandom_range(0, 1));
      reg_write_en_in_exmem = 1'b1;
      dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk);
      chk("idle_stall", {31'h0, stall_out}, 32'h0);
      @(posedge clk); #1;
      chk("idle_req", {31'h0, dmem_req}, 32'h0);
      chk("idle_pc", pc_out_memwb, e_pc);
      chk("idle_rwe", {31'h0, reg_write_en_out_memwb}, {31'h0, e_rwe});
    end
    dmem_ready = 1'b0;
  endtask

  task automatic reset_mid_access();
    int guard = 0;
    pc_in_exmem = 32'h700; alu_result_in_exmem = 32'h80; store_data_in_exmem = 0;
    Rd_in_exmem = 4'd5; opcode_in_exmem = 5'd3; reg_write_en_in_exmem = 1;
    mem_to_reg_in_exmem = 1; mem_read_in_exmem = 1; mem_write_in_exmem = 0;
    enable = 1; dmem_ready = 0;
    while (!dmem_req && guard < 10) begin @(posedge clk); #1; guard++; end
    chk("rst_launch", {31'h0, dmem_req}, 32'h1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rst_after");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dmem_ready = 1'b0; dmem_rdata = 0;
    pc_in_exmem = 0; alu_result_in_exmem = 0; store_data_in_exmem = 0;
    Rd_in_exmem = 0; opcode_in_exmem = 0; reg_write_en_in_exmem = 0;
    mem_to_reg_in_exmem = 0; mem_read_in_exmem = 0; mem_write_in_exmem = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_instr("alu",    32'h10, 32'h1234, 32'h0, 4'd3, 5'd1, 1, 0, 0, 0, 0, 32'h0);
    run_instr("load",   32'h14, 32'h100, 32'h0, 4'd4, 5'd2, 1, 1, 1, 0, 3, 32'hDEADBEEF);
    run_instr("store",  32'h18, 32'h40, 32'hA5A5A5A5, 4'd0, 5'd4, 0, 0, 0, 1, 1, 32'h0);
    run_instr("both",   32'h1C, 32'h44, 32'h1111, 4'd6, 5'd2, 1, 1, 1, 1, 2, 32'hCAFEF00D);
    run_instr("late",   32'h20, 32'h48, 32'h0, 4'd7, 5'd2, 1, 1, 1, 0, TIMEOUT, 32'h600DD00D);
    idle_cycles(2);
    run_instr("tmo",    32'h50, 32'h200, 32'h0, 4'd2, 5'd2, 1, 1, 1, 0, 0, 32'h0);
    run_instr("resume", 32'h54, 32'h5678, 32'h0, 4'd9, 5'd1, 1, 0, 0, 0, 0, 32'h0);
    run_instr("mis_a",  32'h200, 32'h102, 32'h0, 4'd1, 5'd2, 1, 1, 1, 0, 1, 32'h0);
    reset_mid_access();
    run_instr("fresh",  32'h204, 32'h300, 32'h0, 4'd8, 5'd2, 1, 1, 1, 0, 2, 32'h12345678);
    run_instr("mis_b",  32'h208, 32'h102, 32'h0, 4'd1, 5'd2, 1, 1, 1, 0, 1, 32'h0);
    run_instr("mis_c",  32'h300, 32'h43, 32'h0, 4'd1, 5'd4, 0, 0, 0, 1, 1, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic        mr, mw;
      int          r, lat;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      mr = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r <= 5)      lat = $urandom_range(1, 3);
      else if (r == 6) lat = TIMEOUT;
      else if (r == 7) lat = TIMEOUT - 1;
      else if (r == 8) lat = 0;
      else             lat = $urandom_range(4, 8);
      run_instr("rnd", $urandom, a, $urandom, 4'($urandom), 5'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mw, lat, $urandom);
      if ($urandom_range(0, 9) < 3) idle_cycles($urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory Access stage of the 5-stage pipeline: sits between the EX/MEM pipeline register and the Write Back stage. It runs loads and stores against a single-ported data memory with a req/ready handshake, and stalls the upstream pipeline while an access is outstanding. It traps misaligned and timed-out accesses, and owns the MEM/WB pipeline register that feeds Write Back.

## Interface
- TIMEOUT, 16: max ACCESS cycles without `dmem_ready` before abort (≥2).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  pipeline advance; sampled only in IDLE.
- pc_in_exmem, alu_result_in_exmem, store_data_in_exmem  in  32 each  PC, ALU result / effective address, store data.
- Rd_in_exmem  in  4  destination register; opcode_in_exmem  in  5  opcode.
- reg_write_en_in_exmem, mem_to_reg_in_exmem, mem_read_in_exmem, mem_write_in_exmem  in  1 each  control bits.
- dmem_req  out  1  request valid, held until accepted.
- dmem_we  out  1  1 = store.
- dmem_addr, dmem_wdata  out  32 each  word address, store data.
- dmem_ready  in  1  accept; read data valid this cycle.
- dmem_rdata  in  32  load data.
- stall_out  out  1  hold EX/MEM and earlier stages.
- pc_out_memwb, alu_result_out_memwb, mem_read_data_out_memwb  out  32 each  MEM/WB register.
- Rd_out_memwb  out  4; opcode_out_memwb  out  5.
- reg_write_en_out_memwb, mem_to_reg_out_memwb  out  1 each.
- fault  out  1  sticky fault flag, cleared only by reset.
- fault_pc  out  32  PC of the first faulting instruction.

## Operation
- mem_op = mem_read | mem_write. Both set: treat as load.
- misaligned = mem_op & (alu_result[1:0] != 0).
- FSM states are IDLE and ACCESS.
- IDLE, enable=0: MEM/WB holds, stall_out=0, no request.
- IDLE, enable=1, !mem_op: MEM/WB loads the inputs at the edge. mem_read_data = 0.
- IDLE, enable=1, misaligned: no request is issued.
  - MEM/WB loads the instruction with reg_write_en forced 0.
  - fault is set. fault_pc is captured if fault was 0.
- IDLE, enable=1, aligned mem_op: stall_out=1 (combinational).
  - At the edge: dmem_req←1, dmem_we←mem_write, dmem_addr←alu_result, dmem_wdata←store_data, counter←0, go to ACCESS.
  - MEM/WB loads a bubble: reg_write_en=0, mem_to_reg=0, other fields 0.
- ACCESS, dmem_ready=0, counter<TIMEOUT-1: stall_out=1, counter+1, MEM/WB loads a bubble. Request fields stay stable.
- ACCESS, dmem_ready=1: stall_out=0.
  - At the edge: MEM/WB loads the held instruction. A load captures mem_read_data=dmem_rdata; a store captures 0.
  - dmem_req←0, go to IDLE.
- ACCESS, dmem_ready=0, counter==TIMEOUT-1: abort with stall_out=0.
  - MEM/WB loads the instruction with reg_write_en forced 0.
  - fault is set, fault_pc is captured as for misaligned, dmem_req←0, go to IDLE.
- ACCESS ignores enable. An accepted transaction always completes.
- dmem_ready outside ACCESS is ignored.
- Counter is 5 bits min, wide enough for TIMEOUT-1. It never wraps.

## Timing
- Reset: state IDLE, counter 0. All outputs 0: dmem_*, MEM/WB fields, fault, fault_pc.
- Reset mid-ACCESS drops dmem_req immediately and discards the transaction.
- Non-memory op latency: 1 cycle, 0 stall cycles.
- Memory op with ready in the k-th ACCESS cycle (k≥1):
  - stall_out is high for k cycles (the IDLE launch cycle plus k-1 ACCESS cycles).
  - Result appears in MEM/WB k+1 edges after first presentation.
- Zero-wait memory (ready in the first ACCESS cycle): one stall cycle per load or store.
- Timeout: stall_out is high for TIMEOUT cycles. The faulted instruction leaves on edge TIMEOUT+1.
- stall_out is combinational from state, inputs and dmem_ready. It has no path from the MEM/WB outputs.
- Back-to-back memory ops: the edge that leaves ACCESS returns to IDLE. The next op launches from IDLE in the following cycle. Requests are never adjacent; a dmem_req low cycle always separates them.

## Test plan
- ALU op: alu_result=0x1234, Rd=3, reg_write_en=1, enable=1 -> next edge MEM/WB has 0x1234, Rd 3, write enabled, stall_out never high.
- Load at 0x100, memory returns 0xDEADBEEF with ready in the 3rd ACCESS cycle -> stall_out high 3 cycles, dmem_addr stable at 0x100, then MEM/WB mem_read_data=0xDEADBEEF with mem_to_reg=1.
- Store at 0x40 with data 0xA5A5A5A5 and zero-wait ready -> one request cycle with dmem_we=1 and dmem_wdata=0xA5A5A5A5, MEM/WB reg_write_en=0, then a bubble.
- Load at 0x102 -> no dmem_req, fault=1, fault_pc=that PC, reg_write_en_out=0. A later fault at another PC leaves fault_pc unchanged.
- Load with dmem_ready stuck 0 and TIMEOUT=16 -> stall_out high exactly 16 cycles, fault=1, dmem_req low after abort, pipeline resumes.
- Assert reset during ACCESS, then release -> all outputs 0, state IDLE. A fresh load completes normally.
